// File: rtl/registers_pkg.sv
// Shared constants, write-source encoding and the write-priority resolver
// used by both the storage update and the read-port bypass of registers_mp.
package registers_pkg;

  localparam int REG_ZERO     = 0;
  localparam int SP_INDEX_DEF = 29;
  localparam int SP_RESET_DEF = 16380;
  localparam int A0_INDEX_DEF = 4;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_LANE0 = 2'd1,
    SRC_LANE1 = 2'd2,
    SRC_A0    = 2'd3
  } wr_src_e;

  // Which write source owns register 'tgt' this cycle: injection beats the
  // younger lane 1, which beats the older lane 0. Register zero never owns one.
  function automatic wr_src_e resolve_src(
    input logic [31:0] tgt,
    input logic        en0,
    input logic [31:0] addr0,
    input logic        en1,
    input logic [31:0] addr1,
    input logic        a0_en,
    input logic [31:0] a0_idx
  );
    wr_src_e src;
    src = SRC_NONE;
    if (tgt != 32'(REG_ZERO)) begin
      if (en0 && (addr0 == tgt)) src = SRC_LANE0;
      if (en1 && (addr1 == tgt)) src = SRC_LANE1;
      if (a0_en && (a0_idx == tgt)) src = SRC_A0;
    end
    return src;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write bits. A committed write clears a bit, an issued
// destination sets it, and a set in the same cycle as a clear keeps it set.
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                clr_n_i,
  input  logic [NUM_REGS-1:0] clear_i,
  input  logic                set_en_i,
  input  logic [ADDR_W-1:0]   set_addr_i,
  input  logic [ADDR_W-1:0]   query1_i,
  input  logic [ADDR_W-1:0]   query2_i,
  output logic                pend1_o,
  output logic                pend2_o
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  // Next pending vector: clear written registers first so a same-cycle set wins.
  always_comb begin
    pend_d = pend_q & ~clear_i;
    if (set_en_i && (set_addr_i != '0)) begin
      pend_d[set_addr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Pending register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend1_o = pend_q[query1_i];
  assign pend2_o = pend_q[query2_i];

endmodule

// File: rtl/registers_mp.sv
// Multi-ported register bank: two bypassable read ports, a raw display port,
// two retire lanes plus $a0 injection, and a pending-write scoreboard.
module registers_mp
  import registers_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int SP_INDEX = SP_INDEX_DEF,
  parameter int SP_RESET = SP_RESET_DEF,
  parameter int A0_INDEX = A0_INDEX_DEF,
  parameter int BYPASS   = 1
) (
  input  logic              iCLK,
  input  logic              iCLR_N,
  input  logic [ADDR_W-1:0] iRdAddr1,
  input  logic [ADDR_W-1:0] iRdAddr2,
  output logic [DATA_W-1:0] oRdData1,
  output logic [DATA_W-1:0] oRdData2,
  output logic              oPend1,
  output logic              oPend2,
  input  logic [ADDR_W-1:0] iDispAddr,
  output logic [DATA_W-1:0] oDispData,
  input  logic              iWrEn0,
  input  logic [ADDR_W-1:0] iWrAddr0,
  input  logic [DATA_W-1:0] iWrData0,
  input  logic              iWrEn1,
  input  logic [ADDR_W-1:0] iWrAddr1,
  input  logic [DATA_W-1:0] iWrData1,
  input  logic              iA0En,
  input  logic [DATA_W-1:0] iA0Data,
  input  logic              iPendSet,
  input  logic [ADDR_W-1:0] iPendAddr,
  output logic              oReady
);

  localparam logic [DATA_W-1:0] SP_RESET_VAL = DATA_W'(SP_RESET);
  localparam logic [31:0]       A0_IDX       = 32'(A0_INDEX);
  localparam bit                BYP_EN       = (BYPASS != 0);

  // Writes are ignored while reset is held, so every consumer sees gated enables.
  logic wr_en0_g;
  logic wr_en1_g;
  logic a0_en_g;
  assign wr_en0_g = iWrEn0 & iCLR_N;
  assign wr_en1_g = iWrEn1 & iCLR_N;
  assign a0_en_g  = iA0En  & iCLR_N;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic                ready_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [DATA_W-1:0] RST_VAL = (gi == SP_INDEX) ? SP_RESET_VAL : '0;
    wr_src_e           src;
    logic [DATA_W-1:0] regs_d;

    assign src = resolve_src(32'(gi), wr_en0_g, 32'(iWrAddr0), wr_en1_g,
                             32'(iWrAddr1), a0_en_g, A0_IDX);
    assign wr_hit[gi] = (src != SRC_NONE);

    // Select the winning write source for this register, else hold.
    always_comb begin
      regs_d = regs_q[gi];
      case (src)
        SRC_LANE0: regs_d = iWrData0;
        SRC_LANE1: regs_d = iWrData1;
        SRC_A0:    regs_d = iA0Data;
        default:   regs_d = regs_q[gi];
      endcase
    end

    // Storage flop; reset loads zero, or the stack pointer start value.
    always_ff @(posedge iCLK) begin
      if (!iCLR_N) begin
        regs_q[gi] <= RST_VAL;
      end else begin
        regs_q[gi] <= regs_d;
      end
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_pend_raw [2];
  logic              rd_fwd [2];

  assign rd_addr[0] = iRdAddr1;
  assign rd_addr[1] = iRdAddr2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    wr_src_e src;
    assign src = resolve_src(32'(rd_addr[gi]), wr_en0_g, 32'(iWrAddr0), wr_en1_g,
                             32'(iWrAddr1), a0_en_g, A0_IDX);
    assign rd_fwd[gi] = BYP_EN && (src != SRC_NONE);

    // Read mux: forward this cycle's winning write when bypass is enabled.
    always_comb begin
      rd_data[gi] = regs_q[rd_addr[gi]];
      if (BYP_EN) begin
        case (src)
          SRC_LANE0: rd_data[gi] = iWrData0;
          SRC_LANE1: rd_data[gi] = iWrData1;
          SRC_A0:    rd_data[gi] = iA0Data;
          default:   rd_data[gi] = regs_q[rd_addr[gi]];
        endcase
      end
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk        (iCLK),
    .clr_n_i    (iCLR_N),
    .clear_i    (wr_hit),
    .set_en_i   (iPendSet),
    .set_addr_i (iPendAddr),
    .query1_i   (iRdAddr1),
    .query2_i   (iRdAddr2),
    .pend1_o    (rd_pend_raw[0]),
    .pend2_o    (rd_pend_raw[1])
  );

  // Ready rises on the first edge that samples reset released.
  always_ff @(posedge iCLK) begin
    ready_q <= iCLR_N;
  end

  assign oRdData1  = rd_data[0];
  assign oRdData2  = rd_data[1];
  assign oPend1    = rd_pend_raw[0] & ~rd_fwd[0];
  assign oPend2    = rd_pend_raw[1] & ~rd_fwd[1];
  assign oDispData = regs_q[iDispAddr];
  assign oReady    = ready_q;

endmodule

// File: tb/tb_registers_mp.sv
// Bench for registers_mp: three instances (default, no-bypass, 16x16 with
// SP at 13) share one stimulus stream and are checked against an array model.
module tb_registers_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_n;
  logic [4:0]  rd1, rd2, disp, wa0, wa1, pa;
  logic [31:0] wd0, wd1, a0d;
  logic        we0, we1, a0en, pset;

  logic [31:0] a_rd1, a_rd2, a_disp, b_rd1, b_rd2, b_disp;
  logic        a_p1, a_p2, a_rdy, b_p1, b_p2, b_rdy;
  logic [15:0] c_rd1, c_rd2, c_disp;
  logic        c_p1, c_p2, c_rdy;

  int checks = 0;
  int failures = 0;

  registers_mp u_a (
    .iCLK(clk), .iCLR_N(clr_n), .iRdAddr1(rd1), .iRdAddr2(rd2),
    .oRdData1(a_rd1), .oRdData2(a_rd2), .oPend1(a_p1), .oPend2(a_p2),
    .iDispAddr(disp), .oDispData(a_disp),
    .iWrEn0(we0), .iWrAddr0(wa0), .iWrData0(wd0),
    .iWrEn1(we1), .iWrAddr1(wa1), .iWrData1(wd1),
    .iA0En(a0en), .iA0Data(a0d), .iPendSet(pset), .iPendAddr(pa), .oReady(a_rdy)
  );

  registers_mp #(.BYPASS(0)) u_b (
    .iCLK(clk), .iCLR_N(clr_n), .iRdAddr1(rd1), .iRdAddr2(rd2),
    .oRdData1(b_rd1), .oRdData2(b_rd2), .oPend1(b_p1), .oPend2(b_p2),
    .iDispAddr(disp), .oDispData(b_disp),
    .iWrEn0(we0), .iWrAddr0(wa0), .iWrData0(wd0),
    .iWrEn1(we1), .iWrAddr1(wa1), .iWrData1(wd1),
    .iA0En(a0en), .iA0Data(a0d), .iPendSet(pset), .iPendAddr(pa), .oReady(b_rdy)
  );

  registers_mp #(.DATA_W(16), .NUM_REGS(16), .SP_INDEX(13)) u_c (
    .iCLK(clk), .iCLR_N(clr_n), .iRdAddr1(rd1[3:0]), .iRdAddr2(rd2[3:0]),
    .oRdData1(c_rd1), .oRdData2(c_rd2), .oPend1(c_p1), .oPend2(c_p2),
    .iDispAddr(disp[3:0]), .oDispData(c_disp),
    .iWrEn0(we0), .iWrAddr0(wa0[3:0]), .iWrData0(wd0[15:0]),
    .iWrEn1(we1), .iWrAddr1(wa1[3:0]), .iWrData1(wd1[15:0]),
    .iA0En(a0en), .iA0Data(a0d[15:0]), .iPendSet(pset), .iPendAddr(pa[3:0]), .oReady(c_rdy)
  );

  // Reference model: k=0 is the 32x32 bank, k=1 the 16x16 bank.
  logic [31:0] m_reg  [2][32];
  bit          m_pend [2][32];
  bit          m_rdy;

  function automatic int amap(int k, logic [4:0] a);
    return (k != 0) ? int'(a[3:0]) : int'(a);
  endfunction

  function automatic logic [31:0] dmask(int k, logic [31:0] v);
    return (k != 0) ? {16'h0, v[15:0]} : v;
  endfunction

  function automatic bit wrote(int k, int ad);
    return clr_n && (ad != 0) &&
           ((we0 && amap(k, wa0) == ad) || (we1 && amap(k, wa1) == ad) || (a0en && ad == 4));
  endfunction

  // Last-writer-wins in priority order: lane 0, then lane 1, then injection.
  function automatic logic [31:0] exp_rd(int k, bit byp, logic [4:0] a);
    int ad = amap(k, a);
    logic [31:0] v = m_reg[k][ad];
    if (byp && clr_n && ad != 0) begin
      if (we0 && amap(k, wa0) == ad) v = wd0;
      if (we1 && amap(k, wa1) == ad) v = wd1;
      if (a0en && ad == 4) v = a0d;
    end
    return dmask(k, v);
  endfunction

  function automatic bit exp_pend(int k, bit byp, logic [4:0] a);
    int ad = amap(k, a);
    return m_pend[k][ad] && !(byp && wrote(k, ad));
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int n = (k != 0) ? 16 : 32;
      if (!clr_n) begin
        for (int i = 0; i < n; i++) begin
          m_reg[k][i] = '0;
          m_pend[k][i] = 1'b0;
        end
        m_reg[k][(k != 0) ? 13 : 29] = dmask(k, 32'd16380);
      end else begin
        if (we0 && amap(k, wa0) != 0) begin m_reg[k][amap(k, wa0)] = dmask(k, wd0); m_pend[k][amap(k, wa0)] = 1'b0; end
        if (we1 && amap(k, wa1) != 0) begin m_reg[k][amap(k, wa1)] = dmask(k, wd1); m_pend[k][amap(k, wa1)] = 1'b0; end
        if (a0en) begin m_reg[k][4] = dmask(k, a0d); m_pend[k][4] = 1'b0; end
        if (pset && amap(k, pa) != 0) m_pend[k][amap(k, pa)] = 1'b1;
      end
    end
    m_rdy = clr_n;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; a0en = 0; pset = 0;
    wa0 = 0; wa1 = 0; pa = 0; wd0 = 0; wd1 = 0; a0d = 0;
  endtask

  task automatic test_reset();
    clr_n = 0; idle(); rd1 = 0; rd2 = 0; disp = 0;
    step(); step();
    checks++; if (a_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy_low got=%b want=0", a_rdy); end
    clr_n = 1; #1;
    checks++; if (a_rdy !== 1'b0) begin failures++; $display("FAIL rdy_before_edge got=%b want=0", a_rdy); end
    step();
    checks++; if (a_rdy !== 1'b1 || c_rdy !== 1'b1) begin failures++; $display("FAIL rdy_after_edge got=%b/%b want=1", a_rdy, c_rdy); end
    for (int i = 0; i < 32; i++) begin
      disp = 5'(i); rd1 = 5'(i); #1;
      checks++;
      if (a_disp !== ((i == 29) ? 32'd16380 : 32'd0) || a_p1 !== 1'b0) begin
        failures++; $display("FAIL reset_reg%0d got=%h pend=%b want=%h pend=0", i, a_disp, a_p1, (i == 29) ? 32'd16380 : 32'd0);
      end
      if (i < 16) begin
        checks++;
        if (c_disp !== ((i == 13) ? 16'd16380 : 16'd0) || c_p1 !== 1'b0) begin
          failures++; $display("FAIL reset16_reg%0d got=%h pend=%b want=%h pend=0", i, c_disp, c_p1, (i == 13) ? 16'd16380 : 16'd0);
        end
      end
    end
  endtask

  task automatic test_dual_write();
    idle(); we0 = 1; wa0 = 5; wd0 = 32'h11; we1 = 1; wa1 = 5; wd1 = 32'h22; rd1 = 5; disp = 5; #1;
    checks++; if (a_rd1 !== 32'h22) begin failures++; $display("FAIL dual_bypass got=%h want=22", a_rd1); end
    checks++; if (b_rd1 !== 32'h0) begin failures++; $display("FAIL dual_nobypass got=%h want=0", b_rd1); end
    checks++; if (c_rd1 !== 16'h22) begin failures++; $display("FAIL dual_bypass16 got=%h want=22", c_rd1); end
    step(); idle(); #1;
    checks++; if (a_disp !== 32'h22 || b_rd1 !== 32'h22 || c_disp !== 16'h22) begin
      failures++; $display("FAIL dual_stored got=%h/%h/%h want=22", a_disp, b_rd1, c_disp);
    end
  endtask

  task automatic test_injection();
    idle(); a0en = 1; a0d = 32'hA0A0; we1 = 1; wa1 = 4; wd1 = 32'h5; we0 = 1; wa0 = 0; wd0 = 32'hFFFF;
    rd1 = 4; rd2 = 0; #1;
    checks++; if (a_rd1 !== 32'hA0A0) begin failures++; $display("FAIL inj_bypass got=%h want=a0a0", a_rd1); end
    step(); idle(); we1 = 1; wa1 = 0; wd1 = 32'hFFFF; disp = 4; #1;
    checks++; if (a_disp !== 32'hA0A0 || c_disp !== 16'hA0A0) begin failures++; $display("FAIL inj_stored got=%h/%h want=a0a0", a_disp, c_disp); end
    checks++; if (a_rd2 !== 32'h0) begin failures++; $display("FAIL reg0_bypass got=%h want=0", a_rd2); end
    step(); idle(); disp = 0; #1;
    checks++; if (a_disp !== 32'h0 || a_rd2 !== 32'h0) begin failures++; $display("FAIL reg0_stored got=%h/%h want=0", a_disp, a_rd2); end
  endtask

  task automatic test_scoreboard();
    idle(); pset = 1; pa = 7; step(); idle(); rd1 = 7; #1;
    checks++; if (a_p1 !== 1'b1 || b_p1 !== 1'b1 || c_p1 !== 1'b1) begin failures++; $display("FAIL pend_set got=%b%b%b want=111", a_p1, b_p1, c_p1); end
    we0 = 1; wa0 = 7; wd0 = 32'h77; #1;
    checks++; if (a_p1 !== 1'b0 || a_rd1 !== 32'h77) begin failures++; $display("FAIL pend_bypass got=%b/%h want=0/77", a_p1, a_rd1); end
    checks++; if (b_p1 !== 1'b1) begin failures++; $display("FAIL pend_nobypass got=%b want=1", b_p1); end
    step(); idle(); rd1 = 7; #1;
    checks++; if (a_p1 !== 1'b0 || b_p1 !== 1'b0) begin failures++; $display("FAIL pend_cleared got=%b/%b want=0", a_p1, b_p1); end
    pset = 1; pa = 7; we0 = 1; wa0 = 7; wd0 = 32'h78; step(); idle(); rd1 = 7; #1;
    checks++; if (b_p1 !== 1'b1 || a_p1 !== 1'b1) begin failures++; $display("FAIL pend_set_wins got=%b/%b want=1", a_p1, b_p1); end
    pset = 1; pa = 0; step(); idle(); rd2 = 0; #1;
    checks++; if (a_p2 !== 1'b0) begin failures++; $display("FAIL pend_reg0 got=%b want=0", a_p2); end
  endtask

  task automatic test_reset_mid();
    idle(); pset = 1; pa = 3; step();
    clr_n = 0; idle(); we1 = 1; wa1 = 3; wd1 = 32'h33; pset = 1; pa = 3; step();
    idle(); rd1 = 3; disp = 3; #1;
    checks++; if (a_disp !== 32'h0 || a_p1 !== 1'b0 || a_rdy !== 1'b0) begin
      failures++; $display("FAIL reset_mid got=%h pend=%b rdy=%b want=0/0/0", a_disp, a_p1, a_rdy);
    end
    clr_n = 1; step();
    checks++; if (a_rdy !== 1'b1 || a_disp !== 32'h0) begin failures++; $display("FAIL reset_mid_exit got=%b/%h want=1/0", a_rdy, a_disp); end
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  task automatic test_random();
    logic [31:0] got [14];
    logic [31:0] want [14];
    for (int n = 0; n < 400; n++) begin
      clr_n = ($urandom_range(0, 49) != 0);
      we0 = 1'($urandom); we1 = 1'($urandom); a0en = ($urandom_range(0, 3) == 0); pset = 1'($urandom);
      wa0 = raddr(); wa1 = raddr(); pa = raddr(); rd1 = raddr(); rd2 = raddr(); disp = raddr();
      wd0 = $urandom; wd1 = $urandom; a0d = $urandom;
      #1;
      got[0]  = a_rd1;           want[0]  = exp_rd(0, 1, rd1);
      got[1]  = a_rd2;           want[1]  = exp_rd(0, 1, rd2);
      got[2]  = 32'(a_p1);       want[2]  = 32'(exp_pend(0, 1, rd1));
      got[3]  = 32'(a_p2);       want[3]  = 32'(exp_pend(0, 1, rd2));
      got[4]  = a_disp;          want[4]  = m_reg[0][disp];
      got[5]  = 32'(a_rdy);      want[5]  = 32'(m_rdy);
      got[6]  = b_rd1;           want[6]  = exp_rd(0, 0, rd1);
      got[7]  = b_rd2;           want[7]  = exp_rd(0, 0, rd2);
      got[8]  = 32'(b_p1);       want[8]  = 32'(exp_pend(0, 0, rd1));
      got[9]  = {16'h0, c_rd1};  want[9]  = exp_rd(1, 1, rd1);
      got[10] = {16'h0, c_rd2};  want[10] = exp_rd(1, 1, rd2);
      got[11] = 32'(c_p1);       want[11] = 32'(exp_pend(1, 1, rd1));
      got[12] = {16'h0, c_disp}; want[12] = m_reg[1][disp[3:0]];
      got[13] = 32'(c_rdy);      want[13] = 32'(m_rdy);
      for (int j = 0; j < 14; j++) begin
        checks++;
        if (got[j] !== want[j]) begin
          failures++;
          $display("FAIL random cyc=%0d item=%0d got=%h want=%h", n, j, got[j], want[j]);
        end
      end
      $display("txn %0d clr_n=%b we0=%b@%0d we1=%b@%0d a0=%b pset=%b@%0d rd=%0d/%0d", n, clr_n, we0, wa0, we1, wa1, a0en, pset, pa, rd1, rd2);
      step();
    end
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_injection();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
